// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
// A valid/ready command port is turned into an APB SETUP/ACCESS transfer.
// Exactly one response pulse is returned per accepted command. The response
// carries the read data, the slave error flag and a timeout flag.
// Every APB and response output comes straight from a flop, so pready has no
// combinational path to the bus.

module apb_master #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   // command port
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   // response port
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   // APB requester side
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   // The last ACCESS cycle that is still counted. If pready is low when the
   // wait counter holds this value, the transfer is aborted.
   localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

   // FSM state
   state_t                  r_state;
   state_t                  w_next_state;

   // wait counter and transfer qualifiers
   logic [7:0]              r_wait_cnt;
   logic [7:0]              w_wait_cnt_nxt;
   logic                    w_accept;
   logic                    w_access_ok;
   logic                    w_access_to;

   // registered APB outputs and their next values
   logic                    r_psel;
   logic                    r_penable;
   logic                    r_pwrite;
   logic [ADDR_WIDTH-1:0]   r_paddr;
   logic [DATA_WIDTH-1:0]   r_pwdata;
   logic                    w_psel_nxt;
   logic                    w_penable_nxt;
   logic                    w_pwrite_nxt;
   logic [ADDR_WIDTH-1:0]   w_paddr_nxt;
   logic [DATA_WIDTH-1:0]   w_pwdata_nxt;

   // registered response outputs and their next values
   logic                    r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic                    r_rsp_err;
   logic                    r_rsp_timeout;
   logic                    w_rsp_valid_nxt;
   logic [DATA_WIDTH-1:0]   w_rsp_rdata_nxt;
   logic                    w_rsp_err_nxt;
   logic                    w_rsp_timeout_nxt;

   // A command is taken only in IDLE. In any other state the source holds it.
   assign w_accept    = (r_state == ST_IDLE) && cmd_valid;

   // pready is tested before the timeout limit. A late pready in the final
   // counted cycle therefore still completes normally.
   assign w_access_ok = (r_state == ST_ACCESS) && pready;
   assign w_access_to = (r_state == ST_ACCESS) && !pready && (r_wait_cnt == LP_WAIT_LAST);

   // State register: a synchronous reset returns to IDLE and drops any outstanding transfer.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode: IDLE -> SETUP on accept, SETUP -> ACCESS always, ACCESS -> IDLE on ready or abort.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = ST_SETUP;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_SETUP: begin
            w_next_state = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (w_access_ok || w_access_to) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_ACCESS;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Output decode: compute next values of all registered outputs from the state transition.
   always_comb begin
      // The bus strobes follow the state being entered, so they are valid
      // in the same cycle as that state.
      w_psel_nxt    = (w_next_state != ST_IDLE);
      w_penable_nxt = (w_next_state == ST_ACCESS);

      // Address, direction and data are loaded once per transfer and held
      // until the next accept.
      if (w_accept) begin
         w_pwrite_nxt = cmd_write;
         w_paddr_nxt  = cmd_addr;
         w_pwdata_nxt = cmd_wdata;
      end else begin
         w_pwrite_nxt = r_pwrite;
         w_paddr_nxt  = r_paddr;
         w_pwdata_nxt = r_pwdata;
      end

      // The wait counter starts at zero for every transfer. It advances only
      // while ACCESS waits, and saturates at the abort point instead of wrapping.
      if (w_accept) begin
         w_wait_cnt_nxt = 8'd0;
      end else if ((r_state == ST_ACCESS) && !pready && (r_wait_cnt != LP_WAIT_LAST)) begin
         w_wait_cnt_nxt = r_wait_cnt + 8'd1;
      end else begin
         w_wait_cnt_nxt = r_wait_cnt;
      end

      // The response fields change only on a completion. rsp_valid is a
      // single-cycle pulse.
      if (w_access_ok) begin
         w_rsp_valid_nxt   = 1'b1;
         w_rsp_rdata_nxt   = r_pwrite ? {DATA_WIDTH{1'b0}} : prdata;
         w_rsp_err_nxt     = pslverr;
         w_rsp_timeout_nxt = 1'b0;
      end else if (w_access_to) begin
         w_rsp_valid_nxt   = 1'b1;
         w_rsp_rdata_nxt   = {DATA_WIDTH{1'b0}};
         w_rsp_err_nxt     = 1'b1;
         w_rsp_timeout_nxt = 1'b1;
      end else begin
         w_rsp_valid_nxt   = 1'b0;
         w_rsp_rdata_nxt   = r_rsp_rdata;
         w_rsp_err_nxt     = r_rsp_err;
         w_rsp_timeout_nxt = r_rsp_timeout;
      end
   end

   // Output and datapath registers: all cleared by reset, otherwise loaded from the output decode.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= {ADDR_WIDTH{1'b0}};
         r_pwdata      <= {DATA_WIDTH{1'b0}};
         r_wait_cnt    <= 8'd0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_psel        <= w_psel_nxt;
         r_penable     <= w_penable_nxt;
         r_pwrite      <= w_pwrite_nxt;
         r_paddr       <= w_paddr_nxt;
         r_pwdata      <= w_pwdata_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_err     <= w_rsp_err_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
      end
   end

   // cmd_ready is decoded directly from the state register.
   assign cmd_ready   = (r_state == ST_IDLE);

   assign psel        = r_psel;
   assign penable     = r_penable;
   assign pwrite      = r_pwrite;
   assign paddr       = r_paddr;
   assign pwdata      = r_pwdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: self-checking bench for apb_master.
// Each scenario drives the APB slave inputs cycle by cycle. When a command is
// issued, its expected response is pushed to a scoreboard queue. The entry is
// popped and compared when rsp_valid is seen.

module tb_apb_master;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_err, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic          psel, penable, pwrite, pready, pslverr;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata, prdata;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
      logic          to;
   } rsp_t;

   rsp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 sys_clk = ~sys_clk;

   // Advance one clock edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push_exp(input logic [DW-1:0] rd, input logic er, input logic tm);
      rsp_t e;
      e.rdata = rd;
      e.err   = er;
      e.to    = tm;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      tick(); tick(); tick();
      checks++;
      if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0)
         begin errors++; $display("FAIL reset_values: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h rv=%b rd=%h re=%b rt=%b, expected all 0",
            psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout); end
      sys_rst = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      tick();
      checks++;
      if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin errors++; $display("FAIL post_reset_idle: got ready/psel/rv=%b expected 100", {cmd_ready, psel, rsp_valid}); end
   endtask

   task automatic test_write_zero_wait();
      rsp_t e;
      pready = 1'b1; pslverr = 1'b0; prdata = 32'hFFFF_FFFF;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h004; cmd_wdata = 32'h0000_00A5;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wz_ready: got %b expected 1", cmd_ready); end
      push_exp(32'h0, 1'b0, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         tick();
         cmd_valid = 1'b0;
         checks++; if (psel !== 1'(c == 1 || c == 2)) begin errors++; $display("FAIL wz_psel c=%0d: got %b expected %b", c, psel, (c == 1 || c == 2)); end
         checks++; if (penable !== 1'(c == 2)) begin errors++; $display("FAIL wz_penable c=%0d: got %b expected %b", c, penable, (c == 2)); end
         if (psel) begin
            checks++;
            if ({pwrite, paddr, pwdata} !== {1'b1, 12'h004, 32'h0000_00A5}) begin errors++; $display("FAIL wz_bus c=%0d: got pw=%b paddr=%h pwdata=%h expected 1/004/000000a5", c, pwrite, paddr, pwdata); end
         end
         checks++; if (rsp_valid !== 1'(c == 3)) begin errors++; $display("FAIL wz_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, (c == 3)); end
         if (rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin errors++; $display("FAIL wz_rsp: got rd=%h err=%b to=%b expected rd=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to); end
         end
      end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wz_idle_ready: got %b expected 1", cmd_ready); end
   endtask

   task automatic test_read_wait3();
      rsp_t e;
      pready = 1'b0; pslverr = 1'b0; prdata = 32'hDEAD_BEEF;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h008; cmd_wdata = 32'h1357_9BDF;
      push_exp(32'h0000_005A, 1'b0, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         tick();
         cmd_valid = 1'b0;
         pready = (c == 5);
         prdata = (c == 5) ? 32'h0000_005A : 32'hDEAD_BEEF;
         checks++; if (psel !== 1'(c >= 1 && c <= 5)) begin errors++; $display("FAIL rw_psel c=%0d: got %b expected %b", c, psel, (c >= 1 && c <= 5)); end
         checks++; if (penable !== 1'(c >= 2 && c <= 5)) begin errors++; $display("FAIL rw_penable c=%0d: got %b expected %b", c, penable, (c >= 2 && c <= 5)); end
         if (psel) begin
            checks++;
            if ({pwrite, paddr} !== {1'b0, 12'h008}) begin errors++; $display("FAIL rw_bus c=%0d: got pw=%b paddr=%h expected 0/008", c, pwrite, paddr); end
         end
         checks++; if (rsp_valid !== 1'(c == 6)) begin errors++; $display("FAIL rw_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, (c == 6)); end
         if (rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin errors++; $display("FAIL rw_rsp: got rd=%h err=%b to=%b expected rd=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to); end
         end
      end
      pready = 1'b0;
   endtask

   task automatic test_slave_error();
      rsp_t e;
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h7654_3210;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h00C; cmd_wdata = 32'h1234_5678;
      push_exp(32'h0, 1'b1, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         tick();
         cmd_valid = 1'b0;
         // A ready+error pulse during SETUP must have no effect.
         pready  = (c == 1 || c == 3);
         pslverr = (c == 1 || c == 3);
         checks++; if (psel !== 1'(c >= 1 && c <= 3)) begin errors++; $display("FAIL se_psel c=%0d: got %b expected %b", c, psel, (c >= 1 && c <= 3)); end
         checks++; if (penable !== 1'(c == 2 || c == 3)) begin errors++; $display("FAIL se_penable c=%0d: got %b expected %b", c, penable, (c == 2 || c == 3)); end
         checks++; if (rsp_valid !== 1'(c == 4)) begin errors++; $display("FAIL se_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, (c == 4)); end
         if (rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin errors++; $display("FAIL se_rsp: got rd=%h err=%b to=%b expected rd=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to); end
         end
      end
      pready = 1'b0; pslverr = 1'b0;
   endtask

   task automatic test_timeout();
      rsp_t e;
      pready = 1'b0; pslverr = 1'b0; prdata = 32'hCAFE_F00D;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h010; cmd_wdata = 32'h0;
      push_exp(32'h0, 1'b1, 1'b1);
      for (int c = 1; c <= TO + 4; c++) begin
         tick();
         cmd_valid = 1'b0;
         checks++; if (psel !== 1'(c >= 1 && c <= TO + 1)) begin errors++; $display("FAIL to_psel c=%0d: got %b expected %b", c, psel, (c >= 1 && c <= TO + 1)); end
         checks++; if (penable !== 1'(c >= 2 && c <= TO + 1)) begin errors++; $display("FAIL to_penable c=%0d: got %b expected %b", c, penable, (c >= 2 && c <= TO + 1)); end
         checks++; if (rsp_valid !== 1'(c == TO + 2)) begin errors++; $display("FAIL to_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, (c == TO + 2)); end
         if (rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin errors++; $display("FAIL to_rsp: got rd=%h err=%b to=%b expected rd=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to); end
            checks++;
            if (cmd_ready !== 1'b1) begin errors++; $display("FAIL to_ready: got %b expected 1", cmd_ready); end
         end
      end
   endtask

   task automatic test_timeout_edge();
      rsp_t e;
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h1111_2222;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h014; cmd_wdata = 32'h0;
      push_exp(32'h0BAD_CAFE, 1'b0, 1'b0);
      for (int c = 1; c <= TO + 4; c++) begin
         tick();
         cmd_valid = 1'b0;
         // pready arrives in the last counted ACCESS cycle.
         pready = (c == TO + 1);
         prdata = (c == TO + 1) ? 32'h0BAD_CAFE : 32'h1111_2222;
         checks++; if (psel !== 1'(c >= 1 && c <= TO + 1)) begin errors++; $display("FAIL te_psel c=%0d: got %b expected %b", c, psel, (c >= 1 && c <= TO + 1)); end
         checks++; if (rsp_valid !== 1'(c == TO + 2)) begin errors++; $display("FAIL te_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, (c == TO + 2)); end
         if (rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin errors++; $display("FAIL te_rsp: got rd=%h err=%b to=%b expected rd=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to); end
         end
      end
      pready = 1'b0;
   endtask

   task automatic test_back_to_back();
      rsp_t          e;
      logic          bw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [AW-1:0] ba [4] = '{12'h020, 12'h024, 12'h028, 12'h02C};
      logic [DW-1:0] bd [4] = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
      int            sent = 0;
      int            got  = 0;
      bit            hs   = 1'b0;
      bit            prev_pen = 1'b0;
      pready = 1'b1; pslverr = 1'b0;
      cmd_valid = 1'b1; cmd_write = bw[0]; cmd_addr = ba[0]; cmd_wdata = bd[0];
      for (int c = 0; c <= 14; c++) begin
         if (c > 0) begin
            tick();
            // Fields change only after the edge that took the previous command.
            if (hs) begin
               if (sent < 4) begin
                  cmd_write = bw[sent]; cmd_addr = ba[sent]; cmd_wdata = bd[sent];
               end else begin
                  cmd_valid = 1'b0;
               end
            end
         end
         prdata = {20'hC0DE0, paddr};
         checks++;
         if (penable && prev_pen) begin errors++; $display("FAIL b2b_penable_consec c=%0d: got penable high twice expected single", c); end
         prev_pen = penable;
         if (rsp_valid) begin
            checks++;
            if (c != 3 * got + 3) begin errors++; $display("FAIL b2b_rsp_cycle: got %0d expected %0d", c, 3 * got + 3); end
            if (exp_q.size() == 0) begin
               checks++; errors++; $display("FAIL b2b_rsp_extra c=%0d: got rsp_valid expected none", c);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin errors++; $display("FAIL b2b_rsp%0d: got rd=%h err=%b to=%b expected rd=%h err=%b to=%b", got, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to); end
            end
            got++;
         end
         hs = cmd_valid && cmd_ready;
         if (hs) begin
            checks++;
            if (c != 3 * sent) begin errors++; $display("FAIL b2b_hs_cycle: got %0d expected %0d", c, 3 * sent); end
            push_exp(bw[sent] ? 32'h0 : {20'hC0DE0, ba[sent]}, 1'b0, 1'b0);
            sent++;
         end
      end
      checks++;
      if (sent != 4 || got != 4) begin errors++; $display("FAIL b2b_count: got sent=%0d rsp=%0d expected 4/4", sent, got); end
      pready = 1'b0;
   endtask

   task automatic test_reset_mid();
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h030; cmd_wdata = 32'h7777_7777;
      tick(); cmd_valid = 1'b0;
      tick();
      tick();
      checks++;
      if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL rm_in_access: got psel/pen=%b expected 11", {psel, penable}); end
      sys_rst = 1'b1;
      tick();
      checks++;
      if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0)
         begin errors++; $display("FAIL rm_reset_values: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h rv=%b rd=%h re=%b rt=%b, expected all 0",
            psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout); end
      sys_rst = 1'b0;
      pready = 1'b1; prdata = 32'h9999_9999;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if ({rsp_valid, psel, cmd_ready} !== 3'b001) begin errors++; $display("FAIL rm_after c=%0d: got rv/psel/ready=%b expected 001", c, {rsp_valid, psel, cmd_ready}); end
      end
      pready = 1'b0;
   endtask

   initial begin
      sys_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h0; cmd_wdata = 32'h0;
      prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
      test_reset();
      test_write_zero_wait();
      test_read_wait3();
      test_slave_error();
      test_timeout();
      test_timeout_edge();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
